frame_buffer: RTL

Synthesizable 64x64, 24-bit RGB frame store that sits on the memory side of the image processor's pixel port (`row`, `col`, `we`, `out_pix` in; `in_pix` out). It also has a streaming load port that fills the frame in raster order before processing. A streaming dump port reads the processed frame back out afterwards. A small state machine arbitrates between the three.

---
 rtl/frame_buffer_if.sv | 31 +++
 rtl/frame_buffer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/frame_buffer_if.sv
// Pixel-port, load-stream and dump-stream signals of the frame buffer.
// The slave modport is the frame buffer; master is the processor/stream side.
interface frame_buffer_if #(
    parameter int unsigned DIM_W = 6,
    parameter int unsigned PIX_W = 24
);
    logic [DIM_W-1:0] row;
    logic [DIM_W-1:0] col;
    logic             we;
    logic [PIX_W-1:0] out_pix;
    logic [PIX_W-1:0] in_pix;
    logic             ld_valid;
    logic [PIX_W-1:0] ld_pix;
    logic             ld_ready;
    logic             dump_start;
    logic             dp_valid;
    logic [PIX_W-1:0] dp_pix;
    logic             dp_last;
    logic             dp_ready;
    logic             loaded;

    modport master (
        output row, col, we, out_pix, ld_valid, ld_pix, dump_start, dp_ready,
        input  in_pix, ld_ready, dp_valid, dp_pix, dp_last, loaded
    );

    modport slave (
        input  row, col, we, out_pix, ld_valid, ld_pix, dump_start, dp_ready,
        output in_pix, ld_ready, dp_valid, dp_pix, dp_last, loaded
    );
endinterface

// File: rtl/frame_buffer.sv
// 2^DIM_W x 2^DIM_W pixel frame store with raster load stream, processor
// pixel port and raster dump stream, sequenced LOAD -> IDLE <-> DUMP.
module frame_buffer #(
    parameter int unsigned DIM_W = 6,
    parameter int unsigned PIX_W = 24
) (
    input logic           clk,
    input logic           rst_n,
    frame_buffer_if.slave bus
);
    localparam int unsigned ADDR_W = 2 * DIM_W;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_IDLE = 2'd1,
        ST_DUMP = 2'd2
    } state_t;

    state_t            state;
    logic [PIX_W-1:0]  mem [DEPTH];

    logic [ADDR_W-1:0] ld_cnt;
    logic [ADDR_W-1:0] rd_cnt;
    logic              rd_done;

    // prefetch stage: one pixel read ahead of the dump output register
    logic              pf_vld;
    logic              pf_last;
    logic [PIX_W-1:0]  pf_pix;

    logic [PIX_W-1:0]  in_pix_q;
    logic              ld_ready_q;
    logic              dp_valid_q;
    logic [PIX_W-1:0]  dp_pix_q;
    logic              dp_last_q;
    logic              loaded_q;

    logic [ADDR_W-1:0] proc_addr_c;
    logic              ld_fire_c;
    logic              dp_fire_c;
    logic              out_adv_c;
    logic              pf_load_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_waddr_c;
    logic [PIX_W-1:0]  mem_wdata_c;

    assign proc_addr_c = {bus.row, bus.col};
    assign ld_fire_c   = (state == ST_LOAD) && ld_ready_q && bus.ld_valid;
    assign dp_fire_c   = dp_valid_q && bus.dp_ready;
    assign out_adv_c   = !dp_valid_q || bus.dp_ready;
    assign pf_load_c   = (state == ST_DUMP) && !rd_done && (!pf_vld || out_adv_c);

    // single write port shared by the load stream and the processor
    always_comb begin
        mem_we_c    = 1'b0;
        mem_waddr_c = ld_cnt;
        mem_wdata_c = bus.ld_pix;
        if (rst_n) begin
            if (ld_fire_c) begin
                mem_we_c = 1'b1;
            end else if ((state == ST_IDLE) && bus.we) begin
                mem_we_c    = 1'b1;
                mem_waddr_c = proc_addr_c;
                mem_wdata_c = bus.out_pix;
            end
        end
    end

    // storage and dump-side read; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
        if (pf_load_c) begin
            pf_pix <= mem[rd_cnt];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_LOAD;
            ld_cnt     <= '0;
            rd_cnt     <= '0;
            rd_done    <= 1'b0;
            pf_vld     <= 1'b0;
            pf_last    <= 1'b0;
            in_pix_q   <= '0;
            ld_ready_q <= 1'b0;
            dp_valid_q <= 1'b0;
            dp_pix_q   <= '0;
            dp_last_q  <= 1'b0;
            loaded_q   <= 1'b0;
        end else begin
            unique case (state)
                ST_LOAD: begin
                    in_pix_q   <= '0;
                    ld_ready_q <= 1'b1;
                    if (ld_fire_c) begin
                        ld_cnt <= ld_cnt + ADDR_W'(1);
                        if (ld_cnt == '1) begin
                            state      <= ST_IDLE;
                            loaded_q   <= 1'b1;
                            ld_ready_q <= 1'b0;
                        end
                    end
                end

                ST_IDLE: begin
                    // read-first: the write to the same address lands this edge too
                    in_pix_q <= mem[proc_addr_c];
                    if (bus.dump_start) begin
                        state   <= ST_DUMP;
                        rd_cnt  <= '0;
                        rd_done <= 1'b0;
                        pf_vld  <= 1'b0;
                        pf_last <= 1'b0;
                    end
                end

                ST_DUMP: begin
                    if (out_adv_c) begin
                        dp_valid_q <= pf_vld;
                        dp_last_q  <= pf_vld && pf_last;
                        if (pf_vld) begin
                            dp_pix_q <= pf_pix;
                        end
                    end
                    if (pf_load_c) begin
                        pf_vld  <= 1'b1;
                        pf_last <= (rd_cnt == '1);
                        rd_cnt  <= rd_cnt + ADDR_W'(1);
                        if (rd_cnt == '1) begin
                            rd_done <= 1'b1;
                        end
                    end else if (out_adv_c) begin
                        pf_vld <= 1'b0;
                    end
                    if (dp_fire_c && dp_last_q) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

    assign bus.in_pix   = in_pix_q;
    assign bus.ld_ready = ld_ready_q;
    assign bus.dp_valid = dp_valid_q;
    assign bus.dp_pix   = dp_pix_q;
    assign bus.dp_last  = dp_last_q;
    assign bus.loaded   = loaded_q;
endmodule
